target_ddr_tx: RTL and testbench
================================

TARGET_DDR_TX -- requirements
Module: target_ddr_tx

Interface
REQ-001 SHALL have ports: i_sys_clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: i_sys_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: i_sclgen_scl_pos_edge / i_sclgen_scl_neg_edge  in  1 each  single-cycle SCL edge strobes.
REQ-004 SHALL have: i_ddrccc_tx_en  in  1  enable. i_ddrccc_tx_mode  in  4  mode select. i_ddrccc_pre_bit  in  1  preamble bit value.
REQ-005 SHALL have: i_regf_tx_data  in  8  byte to send. i_crc_value  in  5  external CRC.
REQ-006 SHALL have: o_sdahnd_tx_sda  out  1  SDA drive value. o_ddrccc_tx_mode_done  out  1  done pulse. o_regf_rd_en  out  1  next-byte fetch pulse. o_tx_busy  out  1.
REQ-007 Mode encodings SHALL be: 0000 idle, 0001 preamble (1 bit), 0010 data (8 bits), 0100 parity (2 bits), 0101 token_CRC (4'b1100), 0110 CRC_value (5 bits); all others are treated as idle.

Function
REQ-008 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-009 IDLE->LOAD when i_ddrccc_tx_en=1 and mode is valid: mode, bit count and payload latched; data mode latches i_regf_tx_data.
REQ-010 LOAD SHALL drive the MSB on o_sdahnd_tx_sda in the next cycle, then enter SHIFT.
REQ-011 In SHIFT, each pos or neg SCL edge SHALL advance one bit, MSB first, on both edges (DDR).
REQ-012 On the edge that ends the last bit, o_ddrccc_tx_mode_done SHALL pulse for exactly one cycle (state DONE), then return to IDLE.
REQ-013 A data-mode DONE SHALL also pulse o_regf_rd_en for one cycle.
REQ-014 Data bytes SHALL alternate into internal D1 (first) and D2 (second) registers via a first_byte_full flag; the flag toggles on each data DONE and clears on parity DONE.
REQ-015 Parity SHALL send PA1 then PA0: PA1 = XOR of bits 7,5,3,1 of D1 and D2; PA0 = XOR of bits 6,4,2,0 of D1 and D2, XOR 1.
REQ-016 A parity request with only D1 filled SHALL use D2=8'h00.
REQ-017 i_ddrccc_tx_en deasserted mid-SHIFT SHALL abort: SDA=1, no done pulse, IDLE next cycle.
REQ-018 Mode or data changes during SHIFT SHALL be ignored until IDLE.
REQ-019 Simultaneous pos and neg strobes SHALL advance only one bit.
REQ-020 o_tx_busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-021 When idle, SDA SHALL be driven 1.

Reset
REQ-022 Reset SHALL set: state IDLE, o_sdahnd_tx_sda=1, done=0, rd_en=0, busy=0, D1=D2=0, first_byte_full=0, bit counter=0.
REQ-023 Reset asserted mid-transfer SHALL override everything in the same cycle, with no done pulse.

Configuration
REQ-024 With TARGET_TX_CRC_EN defined, an internal CRC-5 SHALL be used: poly x^5+x^2+1, init 5'b11111, updated MSB first over every byte sent in data mode, reset on token_CRC DONE. CRC_value mode SHALL send this internal CRC, and i_crc_value is ignored.
REQ-025 Without TARGET_TX_CRC_EN, CRC_value mode SHALL send i_crc_value, latched at LOAD, and no CRC logic SHALL be present.

Structure
REQ-026 Mode encodings and the token constant 4'b1100 SHALL live in the shared package target_ddr_pkg.
REQ-027 The CRC-5 SHALL be a sub-module target_tx_crc5, instantiated only under TARGET_TX_CRC_EN.

Verification
REQ-028 Data mode, byte 8'hA5: SDA sequence 1,0,1,0,0,1,0,1 over 8 SCL edges, then one done pulse and one rd_en pulse.
REQ-029 Data 8'hA5 then 8'hBD, then parity mode: PA1=1, PA0=0 sent, and first_byte_full is 0 after parity.
REQ-030 token_CRC mode: SDA sequence 1,1,0,0 over 4 edges, then one done pulse.
REQ-031 CRC_value mode without the macro, i_crc_value=5'b11100: SDA sequence 1,1,1,0,0. With the macro, SDA matches a reference CRC-5 computed over the bytes sent.
REQ-032 Preamble mode, i_ddrccc_pre_bit=0: SDA=0 for one edge, then a done pulse. Deassert en after 3 bits of a data transfer: SDA=1, no done pulse.
REQ-033 Assert i_sys_rst mid-SHIFT: next cycle SDA=1, busy=0, done=0, and a subsequent data transfer is correct.

Source files
------------

// File: rtl/target_ddr_pkg.sv
// Shared constants and types for the HDR-DDR target transmitter.
// Mode encodings, FSM states, token constant and CRC-5 parameters.
package target_ddr_pkg;

  localparam int DATA_W = 8;
  localparam int CRC_W  = 5;

  typedef enum logic [3:0] {
    MODE_IDLE      = 4'b0000,
    MODE_PRE       = 4'b0001,
    MODE_DATA      = 4'b0010,
    MODE_PARITY    = 4'b0100,
    MODE_TOKEN_CRC = 4'b0101,
    MODE_CRC_VAL   = 4'b0110
  } tx_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } tx_state_e;

  localparam logic [3:0]       TOKEN_CRC = 4'b1100;
  localparam logic [CRC_W-1:0] CRC5_INIT = 5'b11111;
  localparam logic [CRC_W-1:0] CRC5_POLY = 5'b00101;

  // Any encoding outside the five transmit modes behaves as idle.
  function automatic logic mode_valid(input logic [3:0] m);
    case (m)
      MODE_PRE, MODE_DATA, MODE_PARITY, MODE_TOKEN_CRC, MODE_CRC_VAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/target_tx_crc5.sv
// Running CRC-5 (x^5+x^2+1, init 5'b11111) over whole transmitted bytes, MSB first.
// Only instantiated when TARGET_TX_CRC_EN is defined.
module target_tx_crc5
  import target_ddr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [DATA_W-1:0] data_byte,
  output logic [CRC_W-1:0]  crc
);

  function automatic logic [CRC_W-1:0] crc5_byte(input logic [CRC_W-1:0] c_in,
                                                 input logic [DATA_W-1:0] b);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ b[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ CRC5_POLY;
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= CRC5_INIT;
    end else if (byte_vld) begin
      crc <= crc5_byte(crc, data_byte);
    end
  end

endmodule

// File: rtl/target_ddr_tx.sv
// HDR-DDR target transmitter: serialises preamble/data/parity/CRC fields MSB first,
// one bit per SCL edge. Define TARGET_TX_CRC_EN to use the internal CRC-5 generator.
module target_ddr_tx
  import target_ddr_pkg::*;
(
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_ddrccc_tx_en,
  input  logic [3:0] i_ddrccc_tx_mode,
  input  logic       i_ddrccc_pre_bit,
  input  logic [7:0] i_regf_tx_data,
  input  logic [4:0] i_crc_value,
  output logic       o_sdahnd_tx_sda,
  output logic       o_ddrccc_tx_mode_done,
  output logic       o_regf_rd_en,
  output logic       o_tx_busy
);

  tx_state_e         state_q, state_d;
  tx_mode_e          mode_q;
  logic [3:0]        bits_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] byte_q;
  logic [DATA_W-1:0] d1_q, d2_q;
  logic              first_byte_full_q;
  logic              sda_q;

  logic              scl_edge;
  logic              start;
  logic [DATA_W-1:0] d2_eff;
  logic              pa1, pa0;
  logic [CRC_W-1:0]  crc_src;
  logic [DATA_W-1:0] load_payload;
  logic [3:0]        load_bits;

  // Both strobes in one cycle still count as a single DDR bit.
  assign scl_edge = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign start    = i_ddrccc_tx_en && mode_valid(i_ddrccc_tx_mode);

  assign d2_eff = first_byte_full_q ? '0 : d2_q;
  assign pa1    = ^((d1_q ^ d2_eff) & 8'hAA);
  assign pa0    = (^((d1_q ^ d2_eff) & 8'h55)) ^ 1'b1;

`ifdef TARGET_TX_CRC_EN
  logic [CRC_W-1:0] crc_int;
  logic             unused_crc_value;

  assign unused_crc_value = ^i_crc_value;

  target_tx_crc5 u_crc5 (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .clear     (state_q == ST_DONE && mode_q == MODE_TOKEN_CRC),
    .byte_vld  (state_q == ST_DONE && mode_q == MODE_DATA),
    .data_byte (byte_q),
    .crc       (crc_int)
  );

  assign crc_src = crc_int;
`else
  assign crc_src = i_crc_value;
`endif

  // Fields are left-aligned in an 8-bit shifter so the MSB is always bit 7.
  always_comb begin
    load_payload = '0;
    load_bits    = '0;
    case (i_ddrccc_tx_mode)
      MODE_PRE:       begin load_payload = {i_ddrccc_pre_bit, 7'b0}; load_bits = 4'd1; end
      MODE_DATA:      begin load_payload = i_regf_tx_data;           load_bits = 4'd8; end
      MODE_PARITY:    begin load_payload = {pa1, pa0, 6'b0};         load_bits = 4'd2; end
      MODE_TOKEN_CRC: begin load_payload = {TOKEN_CRC, 4'b0};        load_bits = 4'd4; end
      MODE_CRC_VAL:   begin load_payload = {crc_src, 3'b0};          load_bits = 4'd5; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = i_ddrccc_tx_en ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: begin
        if (!i_ddrccc_tx_en)                  state_d = ST_IDLE;
        else if (scl_edge && bits_q == 4'd1)  state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control path
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q           <= ST_IDLE;
      mode_q            <= MODE_IDLE;
      bits_q            <= '0;
      sda_q             <= 1'b1;
      d1_q              <= '0;
      d2_q              <= '0;
      first_byte_full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          sda_q <= 1'b1;
          if (start) begin
            mode_q <= tx_mode_e'(i_ddrccc_tx_mode);
            bits_q <= load_bits;
          end
        end
        ST_LOAD: sda_q <= i_ddrccc_tx_en ? shreg_q[DATA_W-1] : 1'b1;
        ST_SHIFT: begin
          if (!i_ddrccc_tx_en) begin
            sda_q <= 1'b1;
          end else if (scl_edge) begin
            bits_q <= bits_q - 4'd1;
            sda_q  <= (bits_q == 4'd1) ? 1'b1 : shreg_q[DATA_W-2];
          end
        end
        ST_DONE: begin
          sda_q <= 1'b1;
          if (mode_q == MODE_DATA) begin
            if (first_byte_full_q) d2_q <= byte_q;
            else                   d1_q <= byte_q;
            first_byte_full_q <= ~first_byte_full_q;
          end else if (mode_q == MODE_PARITY) begin
            first_byte_full_q <= 1'b0;
          end
        end
        default: sda_q <= 1'b1;
      endcase
    end
  end

  // Data path
  always_ff @(posedge i_sys_clk) begin
    if (state_q == ST_IDLE && start) begin
      shreg_q <= load_payload;
      byte_q  <= i_regf_tx_data;
    end else if (state_q == ST_SHIFT && scl_edge) begin
      shreg_q <= shreg_q << 1;
    end
  end

  assign o_sdahnd_tx_sda       = sda_q;
  assign o_ddrccc_tx_mode_done = (state_q == ST_DONE);
  assign o_regf_rd_en          = (state_q == ST_DONE) && (mode_q == MODE_DATA);
  assign o_tx_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_target_ddr_tx.sv
// Scoreboard bench for target_ddr_tx: directed scenarios followed by randomized transfers.
// Expected SDA bits and done pulses are queued by the stimulus and checked by a monitor.
module tb_target_ddr_tx;

  logic       clk = 1'b0;
  logic       rst, pos, neg, en, pre;
  logic [3:0] mode;
  logic [7:0] data;
  logic [4:0] crcv;
  logic       sda, done, rd_en, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit is_done;
    bit val;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: the two data slots, fill flag and running CRC.
  bit [7:0] m_d1, m_d2;
  bit       m_full;
  bit [4:0] m_crc;

  target_ddr_tx dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_sclgen_scl_pos_edge (pos),
    .i_sclgen_scl_neg_edge (neg),
    .i_ddrccc_tx_en        (en),
    .i_ddrccc_tx_mode      (mode),
    .i_ddrccc_pre_bit      (pre),
    .i_regf_tx_data        (data),
    .i_crc_value           (crcv),
    .o_sdahnd_tx_sda       (sda),
    .o_ddrccc_tx_mode_done (done),
    .o_regf_rd_en          (rd_en),
    .o_tx_busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // CRC-5 as polynomial long division, one message bit at a time.
  function automatic bit [4:0] ref_crc(input bit [4:0] c, input bit [7:0] b);
    bit [5:0] r;
    r = {1'b0, c};
    for (int i = 7; i >= 0; i--) begin
      r = {r[4:0], 1'b0};
      r[5] = r[5] ^ b[i];
      if (r[5]) r = r ^ 6'b100101;
    end
    return r[4:0];
  endfunction

  function automatic void model_reset();
    m_d1 = 8'h00; m_d2 = 8'h00; m_full = 1'b0; m_crc = 5'b11111;
  endfunction

  // Monitor: one bit per SCL strobe while busy, one done entry per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          checks++; failures++;
          $display("FAIL done_pulse actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("rd_en_at_done", {7'b0, rd_en}, {7'b0, e.val});
        end
      end else if (busy && (pos || neg)) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          checks++; failures++;
          $display("FAIL sda_unexpected_edge actual=%0b required=none", sda);
        end else begin
          e = exp_q.pop_front();
          chk("sda_bit", {7'b0, sda}, {7'b0, e.val});
        end
      end
      if (rd_en && !done) begin
        checks++; failures++;
        $display("FAIL rd_en_stray actual=1 required=0");
      end
    end
  end

  // stop_at < 0: full transfer; otherwise stop after stop_at bits by dropping en or by reset.
  task automatic send(input bit [3:0] md, input bit [7:0] dt, input bit [4:0] cv,
                      input bit pb, input int stop_at, input bit use_rst);
    bit [7:0] pl;
    bit [7:0] d2e;
    int       n;
    int       stop;
    int       w;
    bit       complete;
    pl = 8'h00; n = 0;
    case (md)
      4'b0001: begin pl = {pb, 7'b0}; n = 1; end
      4'b0010: begin pl = dt; n = 8; end
      4'b0100: begin
        d2e = m_full ? 8'h00 : m_d2;
        pl  = {^((m_d1 ^ d2e) & 8'hAA), ~(^((m_d1 ^ d2e) & 8'h55)), 6'b0};
        n   = 2;
      end
      4'b0101: begin pl = 8'hC0; n = 4; end
      4'b0110: begin
`ifdef TARGET_TX_CRC_EN
        pl = {m_crc, 3'b0};
`else
        pl = {cv, 3'b0};
`endif
        n = 5;
      end
      default: n = 0;
    endcase
    complete = (stop_at < 0) || (stop_at >= n);
    stop     = complete ? n : stop_at;
    for (int i = 0; i < stop; i++) exp_q.push_back('{is_done: 1'b0, val: pl[7-i]});
    if (complete) exp_q.push_back('{is_done: 1'b1, val: (md == 4'b0010)});

    @(posedge clk); #1;
    en = 1'b1; mode = md; data = dt; crcv = cv; pre = pb;
    w = 0;
    do begin
      @(posedge clk); #1; w++;
    end while (!busy && w < 10);
    if (!busy) begin
      checks++; failures++;
      $display("FAIL start_timeout actual=idle required=busy");
      en = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk); #1;
    for (int i = 0; i < stop; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 2) == 0) begin
          mode = 4'($urandom); data = 8'($urandom); crcv = 5'($urandom); pre = 1'($urandom);
        end
        @(posedge clk); #1;
      end
      case ($urandom_range(0, 2))
        0: begin pos = 1'b1; neg = 1'b0; end
        1: begin pos = 1'b0; neg = 1'b1; end
        default: begin pos = 1'b1; neg = 1'b1; end
      endcase
      @(posedge clk); #1;
      pos = 1'b0; neg = 1'b0;
    end
    if (complete) begin
      en = 1'b0;
      @(posedge clk); #1;
      chk("busy_after_done", {7'b0, busy}, 8'h00);
      chk("done_consumed", 8'(exp_q.size()), 8'h00);
      exp_q.delete();
      case (md)
        4'b0010: begin
          if (m_full) m_d2 = dt; else m_d1 = dt;
          m_full = ~m_full;
          m_crc  = ref_crc(m_crc, dt);
        end
        4'b0100: m_full = 1'b0;
        4'b0101: m_crc = 5'b11111;
        default: ;
      endcase
    end else begin
      if (use_rst) rst = 1'b1; else en = 1'b0;
      @(posedge clk); #1;
      chk(use_rst ? "rst_sda" : "abort_sda",   {7'b0, sda},  8'h01);
      chk(use_rst ? "rst_busy" : "abort_busy", {7'b0, busy}, 8'h00);
      chk(use_rst ? "rst_done" : "abort_done", {7'b0, done}, 8'h00);
      if (use_rst) begin
        rst = 1'b0; en = 1'b0;
        model_reset();
      end
      @(posedge clk); #1;
      chk("stop_bits_consumed", 8'(exp_q.size()), 8'h00);
      exp_q.delete();
    end
  endtask

  task automatic idle_mode_check(input bit [3:0] md);
    @(posedge clk); #1;
    en = 1'b1; mode = md;
    repeat (3) @(posedge clk);
    #1;
    chk("invalid_mode_busy", {7'b0, busy}, 8'h00);
    en = 1'b0;
  endtask

  initial begin
    bit [3:0] modes[7];
    bit [3:0] bad[6];
    bit [3:0] md;
    int       st;
    modes = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0101, 4'b0110};
    bad   = '{4'b0000, 4'b0011, 4'b0111, 4'b1000, 4'b1100, 4'b1111};
    rst = 1'b1; pos = 1'b0; neg = 1'b0; en = 1'b0; pre = 1'b0;
    mode = 4'b0000; data = 8'h00; crcv = 5'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sda",   {7'b0, sda},   8'h01);
    chk("reset_busy",  {7'b0, busy},  8'h00);
    chk("reset_done",  {7'b0, done},  8'h00);
    chk("reset_rd_en", {7'b0, rd_en}, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    send(4'b0010, 8'hA5, 5'h00, 1'b0, -1, 1'b0);
    send(4'b0010, 8'hBD, 5'h00, 1'b0, -1, 1'b0);
    send(4'b0100, 8'h00, 5'h00, 1'b0, -1, 1'b0);
    send(4'b0101, 8'h00, 5'h00, 1'b0, -1, 1'b0);
    send(4'b0110, 8'h00, 5'b11100, 1'b0, -1, 1'b0);
    send(4'b0001, 8'h00, 5'h00, 1'b0, -1, 1'b0);
    send(4'b0010, 8'h3C, 5'h00, 1'b0, 3, 1'b0);
    send(4'b0010, 8'h5A, 5'h00, 1'b0, 4, 1'b1);
    send(4'b0010, 8'hA5, 5'h00, 1'b0, -1, 1'b0);
    send(4'b0100, 8'h00, 5'h00, 1'b0, -1, 1'b0);
    for (int i = 0; i < 6; i++) idle_mode_check(bad[i]);

    for (int i = 0; i < 80; i++) begin
      md = modes[$urandom_range(0, 6)];
      st = -1;
      if ($urandom_range(0, 9) == 0) st = $urandom_range(0, 1);
      send(md, 8'($urandom), 5'($urandom), 1'($urandom), st,
           ($urandom_range(0, 19) == 0) && (st >= 0));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
